// File: rtl/half_adder.sv
// half_adder: per-lane half adder with a registered copy and a saturating carry-event counter
module half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] cout,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] cout_q,
    output logic [CNT_W-1:0] carry_cnt,
    output logic             cnt_sat
);
    assign sum     = a ^ b;
    assign cout    = a & b;
    assign cnt_sat = &carry_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            cout_q    <= '0;
            carry_cnt <= '0;
        end else begin
            sum_q     <= sum;
            cout_q    <= cout;
            carry_cnt <= clr_cnt ? '0 : (|cout && !cnt_sat) ? carry_cnt + 1'b1 : carry_cnt;
        end
    end
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: directed bench for a 4-lane/16-bit instance and a 1-lane/2-bit saturation instance
`timescale 1ns/1ps
module tb_half_adder;
    logic clk, rst_n, run_clk;
    logic [3:0] a4, b4, sum4, cout4, sum_q4, cout_q4;
    logic [15:0] carry_cnt4;
    logic clr4, cnt_sat4;
    logic [0:0] a1, b1, sum1, cout1, sum_q1, cout_q1;
    logic [1:0] carry_cnt1;
    logic clr1, cnt_sat1;
    int checks = 0;
    int errors = 0;
    logic [3:0] m4_sq, m4_cq;
    logic [0:0] m1_sq, m1_cq;
    int m4_cnt, m1_cnt;

    half_adder #(.WIDTH(4), .CNT_W(16)) u4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .clr_cnt(clr4),
        .sum(sum4), .cout(cout4), .sum_q(sum_q4), .cout_q(cout_q4),
        .carry_cnt(carry_cnt4), .cnt_sat(cnt_sat4)
    );
    half_adder #(.WIDTH(1), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .clr_cnt(clr1),
        .sum(sum1), .cout(cout1), .sum_q(sum_q1), .cout_q(cout_q1),
        .carry_cnt(carry_cnt1), .cnt_sat(cnt_sat1)
    );

    initial begin
        clk = 0;
        wait (run_clk);
        forever #5 clk = ~clk;
    end

    // each lane adds two bits arithmetically: low bit is sum, high bit is carry
    function automatic logic [3:0] lane_sum(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ((int'(x[i]) + int'(y[i])) % 2) == 1;
        return r;
    endfunction
    function automatic logic [3:0] lane_cout(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (int'(x[i]) + int'(y[i])) >= 2;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4_sq = '0; m4_cq = '0; m4_cnt = 0;
            m1_sq = '0; m1_cq = '0; m1_cnt = 0;
        end else begin
            m4_sq = lane_sum(a4, b4);
            m4_cq = lane_cout(a4, b4);
            m4_cnt = clr4 ? 0 : (m4_cq != 0 && m4_cnt < 65535) ? m4_cnt + 1 : m4_cnt;
            m1_sq = lane_sum({3'b0, a1}, {3'b0, b1}) & 4'b1;
            m1_cq = lane_cout({3'b0, a1}, {3'b0, b1}) & 4'b1;
            m1_cnt = clr1 ? 0 : (m1_cq != 0 && m1_cnt < 3) ? m1_cnt + 1 : m1_cnt;
        end
    end

    always @(negedge clk) begin
        check("sum4", {28'b0, sum4}, {28'b0, lane_sum(a4, b4)});
        check("cout4", {28'b0, cout4}, {28'b0, lane_cout(a4, b4)});
        check("sum_q4", {28'b0, sum_q4}, {28'b0, m4_sq});
        check("cout_q4", {28'b0, cout_q4}, {28'b0, m4_cq});
        check("cnt4", {16'b0, carry_cnt4}, m4_cnt);
        check("sat4", {31'b0, cnt_sat4}, {31'b0, m4_cnt == 65535});
        check("sum_q1", {31'b0, sum_q1}, {31'b0, m1_sq});
        check("cout_q1", {31'b0, cout_q1}, {31'b0, m1_cq});
        check("cnt1", {30'b0, carry_cnt1}, m1_cnt);
        check("sat1", {31'b0, cnt_sat1}, {31'b0, m1_cnt == 3});
    end

    initial begin
        int pts[5]  = '{10, 15, 20, 30, 40};
        int ps[5]   = '{1, 0, 1, 1, 0};
        int pc[5]   = '{0, 1, 0, 0, 0};
        int seq[5]  = '{1, 2, 3, 3, 3};
        rst_n = 0; run_clk = 0; clr4 = 0; clr1 = 0;
        a4 = '0; b4 = '0; a1 = '0; b1 = '0;
        for (int t = 0; t < 60; t++) begin
            a1 = ((t / 10) % 2) == 1;
            b1 = ((t / 15) % 2) == 1;
            #1;
            check("tt_sum", {31'b0, sum1}, {31'b0, lane_sum({3'b0, a1}, {3'b0, b1}) != 0});
            check("tt_cout", {31'b0, cout1}, {31'b0, lane_cout({3'b0, a1}, {3'b0, b1}) != 0});
            for (int k = 0; k < 5; k++)
                if (t == pts[k]) begin
                    check("tt_pt_sum", {31'b0, sum1}, ps[k]);
                    check("tt_pt_cout", {31'b0, cout1}, pc[k]);
                end
        end
        check("rst_sum_q", {28'b0, sum_q4}, 0);
        check("rst_cout_q", {28'b0, cout_q4}, 0);
        check("rst_cnt", {16'b0, carry_cnt4}, 0);
        check("rst_sat", {31'b0, cnt_sat4}, 0);
        a1 = '0; b1 = '0;
        run_clk = 1;
        @(posedge clk); #2;
        rst_n = 1;
        a4 = 4'b0001; b4 = 4'b0001;
        @(posedge clk); #1;
        check("lat1_sum_q", {28'b0, sum_q4}, 0);
        check("lat1_cout_q", {28'b0, cout_q4}, 1);
        b4 = 4'b0000;
        @(posedge clk); #1;
        check("lat2_sum_q", {28'b0, sum_q4}, 1);
        check("lat2_cout_q", {28'b0, cout_q4}, 0);
        clr4 = 1;
        @(posedge clk); #1;
        check("clr_cnt", {16'b0, carry_cnt4}, 0);
        clr4 = 0; a4 = 4'b0001; b4 = 4'b0001;
        repeat (7) @(posedge clk);
        #1;
        check("cnt7", {16'b0, carry_cnt4}, 7);
        clr4 = 1;
        @(posedge clk); #1;
        check("clr_wins", {16'b0, carry_cnt4}, 0);
        clr4 = 0; a4 = '0; b4 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("hold0", {16'b0, carry_cnt4}, 0);
        a4 = 4'b0001; b4 = 4'b0001;
        repeat (5) @(posedge clk);
        #2;
        check("pre_rst_cnt", {16'b0, carry_cnt4}, 5);
        check("pre_rst_cout_q", {28'b0, cout_q4}, 1);
        rst_n = 0;
        #1;
        check("arst_sum_q", {28'b0, sum_q4}, 0);
        check("arst_cout_q", {28'b0, cout_q4}, 0);
        check("arst_cnt", {16'b0, carry_cnt4}, 0);
        check("arst_sat", {31'b0, cnt_sat4}, 0);
        a4 = 4'b0011; b4 = 4'b0110;
        #1;
        check("arst_sum", {28'b0, sum4}, 4'b0101);
        check("arst_cout", {28'b0, cout4}, 4'b0010);
        @(negedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        check("post_rst_cnt", {16'b0, carry_cnt4}, 1);
        a4 = 4'b1100; b4 = 4'b1010;
        #1;
        check("ml_sum", {28'b0, sum4}, 4'b0110);
        check("ml_cout", {28'b0, cout4}, 4'b1000);
        a4 = 4'b1110; b4 = 4'b1011;
        @(posedge clk); #1;
        check("ml_cnt_once", {16'b0, carry_cnt4}, 2);
        a4 = 4'b0101; b4 = 4'b1010;
        #1;
        check("ml_nocarry", {28'b0, cout4}, 0);
        @(posedge clk); #1;
        check("ml_noinc", {16'b0, carry_cnt4}, 2);
        a1 = 1'b1; b1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("sat_seq", {30'b0, carry_cnt1}, seq[k]);
            check("sat_flag", {31'b0, cnt_sat1}, {31'b0, k >= 2});
        end
        clr1 = 1;
        @(posedge clk); #1;
        check("sat_clr", {30'b0, carry_cnt1}, 0);
        check("sat_clr_flag", {31'b0, cnt_sat1}, 0);
        clr1 = 0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
